fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one instruction at a time from instruction
// memory, holds it for the downstream stage until it has finished executing,
// then computes the next PC (sequential, branch/jump target or JALR target).
// Optional feature macro: FETCH_MISALIGN_CHK_EN -- when defined, a misaligned
// next PC sets a sticky error flag and parks the unit in HALT until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic        Jalr,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    input  logic        ins_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        ins_valid,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] target_d;
    logic [31:0] next_pc_d;

`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_q;
`endif

    // Next-PC selection; JALR takes priority over a taken branch/jump.
    always_comb begin
        target_d = pc_q + 32'd4;
        if (Jalr) begin
            target_d = ALUResult & ~32'h0000_0001;
        end else if (PCSrc) begin
            target_d = PCTarget;
        end
`ifdef FETCH_MISALIGN_CHK_EN
        next_pc_d = target_d;
`else
        // Without the checker the low bits are simply dropped so the PC is
        // always word aligned.
        next_pc_d = target_d & ~32'h0000_0003;
`endif
    end

    // Fetch state machine with registered request/valid flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            count_q    <= 32'd0;
            req_q      <= 1'b1;
            valid_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    // Single outstanding request: wait for the response,
                    // which may arrive in the same cycle as the request.
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Branch inputs are only meaningful on the handshake.
                    if (ins_ready) begin
                        pc_q    <= next_pc_d;
                        count_q <= count_q + 32'd1;
                        valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                        if (next_pc_d[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            req_q      <= 1'b0;
                            state_q    <= HALT;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
`else
                        req_q   <= 1'b1;
                        state_q <= FETCH;
`endif
                    end
                end
                HALT: begin
                    // Parked until reset; nothing is requested or presented.
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // Request and valid are suppressed for as long as reset is held.
    assign imem_req    = req_q & ~reset;
    assign ins_valid   = valid_q & ~reset;
    assign imem_addr   = pc_q & ~32'h0000_0003;
    assign Instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign fetch_count = count_q;
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized fetch/hold
// traffic checked against a transaction-level model of the fetch sequence.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc, Jalr, ins_ready, imem_rvalid;
    logic [31:0] PCTarget, ALUResult, imem_rdata;
    logic        imem_req, ins_valid, funct7b5, misalign_err;
    logic [31:0] imem_addr, Instr, PC, PCPlus4, fetch_count;
    logic [6:0]  op;
    logic [2:0]  funct3;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .Jalr(Jalr),
        .PCTarget(PCTarget), .ALUResult(ALUResult), .ins_ready(ins_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .ins_valid(ins_valid),
        .Instr(Instr), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .PC(PC), .PCPlus4(PCPlus4), .fetch_count(fetch_count),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic [31:0] exp_instr;
    logic        halted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic randomize_ctl();
        PCSrc     = 1'($urandom);
        Jalr      = 1'($urandom);
        PCTarget  = $urandom;
        ALUResult = $urandom;
    endtask

    // Reset for two cycles (optionally on top of whatever handshake is driven).
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_valid", ins_valid, 0);
        @(negedge clk);
        check_eq("rst_pc", PC, RST_PC);
        check_eq("rst_count", fetch_count, 0);
        check_eq("rst_instr", Instr, 32'h13);
        check_eq("rst_misalign", misalign_err, 0);
        check_eq("rst_req2", imem_req, 0);
        reset = 1'b0; ins_ready = 1'b0; imem_rvalid = 1'b0;
        exp_pc = RST_PC; exp_count = 0; halted = 1'b0;
    endtask

    // One fetch: request observed, wait_n idle cycles, then the response.
    task automatic do_fetch(input int wait_n);
        #1;
        check_eq("req", imem_req, 1);
        check_eq("addr", imem_addr, exp_pc);
        check_eq("valid_fetch", ins_valid, 0);
        for (int i = 0; i < wait_n; i++) begin
            imem_rvalid = 1'b0;
            ins_ready   = 1'($urandom);
            randomize_ctl();
            @(negedge clk);
            check_eq("req_wait", imem_req, 1);
            check_eq("addr_wait", imem_addr, exp_pc);
            check_eq("valid_wait", ins_valid, 0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        ins_ready   = 1'($urandom);
        @(negedge clk);
        imem_rvalid = 1'b0; ins_ready = 1'b0; imem_rdata = $urandom;
        exp_instr = mem_word(exp_pc);
        check_eq("valid_hold", ins_valid, 1);
        check_eq("req_hold", imem_req, 0);
        check_eq("instr", Instr, exp_instr);
        check_eq("op", {25'd0, op}, {25'd0, exp_instr[6:0]});
        check_eq("funct3", {29'd0, funct3}, {29'd0, exp_instr[14:12]});
        check_eq("funct7b5", {31'd0, funct7b5}, {31'd0, exp_instr[30]});
        check_eq("pc_hold", PC, exp_pc);
        check_eq("pcplus4", PCPlus4, exp_pc + 32'd4);
    endtask

    // Hold the instruction hold_n cycles (noise on ignored inputs), then handshake.
    task automatic do_hold(input int hold_n, input logic src, input logic jal,
                           input logic [31:0] tgt, input logic [31:0] alu);
        logic [31:0] nxt;
        for (int i = 0; i < hold_n; i++) begin
            ins_ready   = 1'b0;
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            randomize_ctl();
            @(negedge clk);
            check_eq("valid_stall", ins_valid, 1);
            check_eq("instr_stall", Instr, exp_instr);
            check_eq("pc_stall", PC, exp_pc);
            check_eq("req_stall", imem_req, 0);
        end
        imem_rvalid = 1'b0;
        PCSrc = src; Jalr = jal; PCTarget = tgt; ALUResult = alu;
        ins_ready = 1'b1;
        @(negedge clk);
        ins_ready = 1'b0;
        if (jal)      nxt = {alu[31:1], 1'b0};
        else if (src) nxt = tgt;
        else          nxt = exp_pc + 32'd4;
`ifndef FETCH_MISALIGN_CHK_EN
        nxt[1:0] = 2'b00;
`endif
        exp_count = exp_count + 1;
        $display("txn %0d: pc=%h instr=%h src=%0d jalr=%0d next=%h",
                 exp_count, exp_pc, exp_instr, src, jal, nxt);
        check_eq("count", fetch_count, exp_count);
        check_eq("valid_after", ins_valid, 0);
        check_eq("pc_next", PC, nxt);
        exp_pc = nxt;
        if (nxt[1:0] != 2'b00) begin
            halted = 1'b1;
            check_eq("misalign_set", misalign_err, 1);
            check_eq("req_halt", imem_req, 0);
        end else begin
            check_eq("misalign_clr", misalign_err, 0);
        end
    endtask

    initial begin
        reset = 1'b1; PCSrc = 0; Jalr = 0; PCTarget = 0; ALUResult = 0;
        ins_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        exp_pc = RST_PC; exp_count = 0; exp_instr = 32'h13; halted = 1'b0;
        @(negedge clk);
        do_reset();

        // Zero-wait fetch of addi at address 0, then sequential handshake.
        do_fetch(0);
        check_eq("op_addi", {25'd0, op}, 32'h13);
        check_eq("f3_addi", {29'd0, funct3}, 32'h0);
        do_hold(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("pc_after_first", PC, 32'h4);

        // Three-cycle memory wait, stall of five cycles, jump to 0x100.
        do_fetch(3);
        do_hold(5, 1'b1, 1'b0, 32'h100, 32'h0);
        // Branch from 0x100 to 0x80.
        do_fetch(0);
        do_hold(0, 1'b1, 1'b0, 32'h80, 32'h0);
        check_eq("addr_branch", imem_addr, 32'h80);
        do_fetch(1);
        do_hold(1, 1'b1, 1'b0, 32'h100, 32'h0);
        // JALR wins over PCSrc.
        do_fetch(0);
        do_hold(0, 1'b1, 1'b1, 32'h80, 32'h205);
        check_eq("addr_jalr", imem_addr, 32'h204);
        // PC+4 wraps at the top of the address space.
        do_fetch(0);
        do_hold(0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        do_fetch(2);
        check_eq("pcplus4_wrap", PCPlus4, 32'h0);
        do_hold(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("pc_wrap", PC, 32'h0);

        // Misaligned JALR target from 0x100.
        do_fetch(0);
        do_hold(0, 1'b1, 1'b0, 32'h100, 32'h0);
        do_fetch(0);
        do_hold(0, 1'b0, 1'b1, 32'h0, 32'h102);
        if (halted) begin
            for (int i = 0; i < 3; i++) begin
                imem_rvalid = 1'b1; ins_ready = 1'b1; randomize_ctl();
                @(negedge clk);
                check_eq("halt_req", imem_req, 0);
                check_eq("halt_valid", ins_valid, 0);
                check_eq("halt_sticky", misalign_err, 1);
            end
            do_reset();
        end else begin
            check_eq("addr_forced", imem_addr, 32'h100);
        end

        // Reset during the memory wait at PC 0x40.
        do_fetch(0);
        do_hold(0, 1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        check_eq("addr_40", imem_addr, 32'h40);
        @(negedge clk);
        do_reset();

        // Reset coinciding with a handshake.
        do_fetch(1);
        ins_ready = 1'b1; PCSrc = 1'b1; PCTarget = 32'h200;
        do_reset();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic        src, jal;
            logic [31:0] tgt, alu;
            src = 1'($urandom);
            jal = ($urandom_range(0, 3) == 0);
            tgt = $urandom & 32'h0000_0FFC;
            alu = $urandom & 32'h0000_0FFD;
`ifndef FETCH_MISALIGN_CHK_EN
            tgt = tgt | 32'($urandom_range(0, 3));
            alu = alu | 32'($urandom_range(0, 3));
`endif
            do_fetch($urandom_range(0, 3));
            do_hold($urandom_range(0, 3), src, jal, tgt, alu);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
